// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface load_store_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request/response data-memory transaction per
// access, with byte enables, lane-replicated stores and extended loads.
module load_store_unit (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    input  logic [4:0]                rd_addr,
    output logic                      lsu_busy,
    output logic                      misaligned,
    output logic                      load_valid,
    output logic [31:0]               load_data,
    output logic [4:0]                load_rd,
    load_store_unit_if.master         bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept, req_present, aligned, req_ok;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;

    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_uns;
    logic        lat_load;
    logic [4:0]  lat_rd;
    logic [31:0] rdata_sh;
    logic [31:0] ld_ext;

    assign accept      = (state == IDLE) || (state == DONE);
    assign req_present = mem_read | mem_write;

    always_comb begin
        aligned = 1'b0;
        case (mem_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign req_ok     = accept & req_present & aligned;
    assign misaligned = accept & req_present & ~aligned;
    assign lsu_busy   = req_ok | (state == REQ) | (state == RESP);

    // Request driven straight from state so reset drops it without a clock.
    assign bus.dmem_req = (state == REQ);

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = store_data;
        case (mem_size)
            2'b00: begin
                be_fmt    = 4'b0001 << addr[1:0];
                wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << {addr[1], 1'b0};
                wdata_fmt = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = req_ok ? REQ : IDLE;
            REQ:        if (bus.dmem_gnt)    state_nxt = RESP;
            RESP:       if (bus.dmem_rvalid) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
            lat_size       <= '0;
            lat_off        <= '0;
            lat_uns        <= 1'b0;
            lat_load       <= 1'b0;
            lat_rd         <= '0;
        end else if (req_ok) begin
            bus.dmem_we    <= ~mem_read;
            bus.dmem_addr  <= {addr[31:2], 2'b00};
            bus.dmem_be    <= be_fmt;
            bus.dmem_wdata <= wdata_fmt;
            lat_size       <= mem_size;
            lat_off        <= addr[1:0];
            lat_uns        <= mem_unsigned;
            lat_load       <= mem_read;
            lat_rd         <= rd_addr;
        end
    end

    // Halfword offsets are always 0 or 2, so one byte-granular shift serves both.
    assign rdata_sh = bus.dmem_rdata >> {lat_off, 3'b000};

    always_comb begin
        ld_ext = bus.dmem_rdata;
        case (lat_size)
            2'b00:   ld_ext = lat_uns ? {24'b0, rdata_sh[7:0]}
                                      : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   ld_ext = lat_uns ? {16'b0, rdata_sh[15:0]}
                                      : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid <= 1'b0;
            load_data  <= '0;
            load_rd    <= '0;
        end else begin
            load_valid <= 1'b0;
            if ((state == RESP) && bus.dmem_rvalid && lat_load) begin
                load_valid <= 1'b1;
                load_data  <= ld_ext;
                load_rd    <= lat_rd;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: checks at negedge, drives at negedge.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] addr = '0, store_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        lsu_busy, misaligned, load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    int          checks = 0, failures = 0;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .store_data(store_data),
        .rd_addr(rd_addr), .lsu_busy(lsu_busy), .misaligned(misaligned),
        .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rda);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; store_data = sd; rd_addr = rda;
    endtask

    task automatic drop_req();
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b want 0", bus.dmem_req); end
        checks++; if (bus.dmem_be !== 4'b0) begin failures++; $display("FAIL rst_be got %b want 0", bus.dmem_be); end
        checks++; if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== 65'b0) begin failures++; $display("FAIL rst_bus got we=%b a=%h wd=%h want 0", bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); end
        checks++; if ({load_valid, load_data, load_rd, lsu_busy} !== 39'b0) begin failures++; $display("FAIL rst_load got lv=%b ld=%h rd=%0d busy=%b want 0", load_valid, load_data, load_rd, lsu_busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lb();
        int busy_cnt = 0;
        drive(1, 0, 2'b00, 0, 32'h1003, 32'h0, 5'd3);
        #1;
        checks++; if (lsu_busy !== 1'b1 || misaligned !== 1'b0) begin failures++; $display("FAIL lb_accept got busy=%b mis=%b want 1 0", lsu_busy, misaligned); end
        busy_cnt += lsu_busy;
        step(); // T+1 REQ
        busy_cnt += lsu_busy;
        checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h1000 || bus.dmem_be !== 4'b1000 || bus.dmem_we !== 1'b0)
            begin failures++; $display("FAIL lb_bus got req=%b a=%h be=%b we=%b want 1 00001000 1000 0", bus.dmem_req, bus.dmem_addr, bus.dmem_be, bus.dmem_we); end
        bus.dmem_gnt = 1'b1;
        step(); // T+2 RESP
        busy_cnt += lsu_busy;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FF_1234;
        checks++; if (bus.dmem_req !== 1'b0 || load_valid !== 1'b0) begin failures++; $display("FAIL lb_resp got req=%b lv=%b want 0 0", bus.dmem_req, load_valid); end
        @(negedge clk); // T+3 DONE
        bus.dmem_rvalid = 1'b0; drop_req();
        #1;
        busy_cnt += lsu_busy;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'hFFFF_FF80 || load_rd !== 5'd3)
            begin failures++; $display("FAIL lb_data got lv=%b ld=%h rd=%0d want 1 ffffff80 3", load_valid, load_data, load_rd); end
        checks++; if (busy_cnt !== 3) begin failures++; $display("FAIL lb_busy_cycles got %0d want 3", busy_cnt); end
        step();
        checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL lb_pulse got %b want 0", load_valid); end
    endtask

    task automatic test_lhu();
        drive(1, 0, 2'b01, 1, 32'h2002, 32'h0, 5'd17);
        step();
        checks++; if (bus.dmem_be !== 4'b1100 || bus.dmem_addr !== 32'h2000) begin failures++; $display("FAIL lhu_bus got be=%b a=%h want 1100 00002000", bus.dmem_be, bus.dmem_addr); end
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hBEEF_0000;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0; drop_req();
        #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'h0000_BEEF || load_rd !== 5'd17)
            begin failures++; $display("FAIL lhu_data got lv=%b ld=%h rd=%0d want 1 0000beef 17", load_valid, load_data, load_rd); end
        step();
    endtask

    task automatic test_sb();
        bit saw_lv = 0;
        drive(0, 1, 2'b00, 0, 32'h10, 32'h1234_56AB, 5'd9);
        step();
        checks++; if (bus.dmem_we !== 1'b1 || bus.dmem_be !== 4'b0001 || bus.dmem_wdata !== 32'hABAB_ABAB || bus.dmem_addr !== 32'h10)
            begin failures++; $display("FAIL sb_bus got we=%b be=%b wd=%h a=%h want 1 0001 abababab 00000010", bus.dmem_we, bus.dmem_be, bus.dmem_wdata, bus.dmem_addr); end
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0; drop_req();
        #1;
        saw_lv = load_valid;
        checks++; if (lsu_busy !== 1'b0) begin failures++; $display("FAIL sb_done_busy got %b want 0", lsu_busy); end
        step();
        saw_lv |= load_valid;
        checks++; if (saw_lv !== 1'b0) begin failures++; $display("FAIL sb_no_lv got %b want 0", saw_lv); end
    endtask

    task automatic test_fault();
        bit saw_req = 0;
        drive(1, 0, 2'b10, 0, 32'h0006, 32'h0, 5'd4);
        #1;
        checks++; if (misaligned !== 1'b1 || lsu_busy !== 1'b0) begin failures++; $display("FAIL lw_mis got mis=%b busy=%b want 1 0", misaligned, lsu_busy); end
        repeat (2) begin step(); saw_req |= bus.dmem_req | load_valid; end
        drive(0, 1, 2'b11, 0, 32'h0000, 32'h0, 5'd4);
        #1;
        checks++; if (misaligned !== 1'b1 || lsu_busy !== 1'b0) begin failures++; $display("FAIL size11_mis got mis=%b busy=%b want 1 0", misaligned, lsu_busy); end
        repeat (2) begin step(); saw_req |= bus.dmem_req | load_valid; end
        drop_req();
        #1;
        checks++; if (saw_req !== 1'b0) begin failures++; $display("FAIL fault_no_bus got %b want 0", saw_req); end
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL fault_clear got %b want 0", misaligned); end
    endtask

    task automatic test_back_to_back();
        bit bad = 0;
        drive(0, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 5'd0);
        step();
        repeat (3) begin // grant withheld
            bad |= (bus.dmem_req !== 1'b1) | (lsu_busy !== 1'b1) | (bus.dmem_addr !== 32'h40)
                 | (bus.dmem_be !== 4'hF) | (bus.dmem_wdata !== 32'hDEAD_BEEF) | (bus.dmem_we !== 1'b1)
                 | (misaligned !== 1'b0);
            step();
        end
        bad |= (bus.dmem_req !== 1'b1);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        repeat (2) begin // rvalid delayed
            bad |= (lsu_busy !== 1'b1) | (bus.dmem_req !== 1'b0);
            step();
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL sw_wait_stable got bad=%b want 0", bad); end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0;
        @(negedge clk); // DONE of SW
        bus.dmem_rvalid = 1'b0;
        drop_req();
        #1;
        checks++; if (lsu_busy !== 1'b0 || load_valid !== 1'b0) begin failures++; $display("FAIL sw_done got busy=%b lv=%b want 0 0", lsu_busy, load_valid); end
        drive(1, 0, 2'b10, 0, 32'h80, 32'h0, 5'd21);
        #1;
        checks++; if (lsu_busy !== 1'b1 || misaligned !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%b mis=%b want 1 0", lsu_busy, misaligned); end
        step();
        checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== 32'h80 || bus.dmem_we !== 1'b0 || bus.dmem_be !== 4'hF)
            begin failures++; $display("FAIL b2b_req got req=%b a=%h we=%b be=%b want 1 00000080 0 1111", bus.dmem_req, bus.dmem_addr, bus.dmem_we, bus.dmem_be); end
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0; drop_req();
        #1;
        checks++; if (load_valid !== 1'b1 || load_data !== 32'hCAFE_F00D || load_rd !== 5'd21)
            begin failures++; $display("FAIL b2b_load got lv=%b ld=%h rd=%0d want 1 cafef00d 21", load_valid, load_data, load_rd); end
        step();
    endtask

    task automatic test_reset_abort();
        bit bad = 0;
        drive(1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd7);
        step();
        bus.dmem_gnt = 1'b1;
        step(); // RESP
        bus.dmem_gnt = 1'b0;
        drop_req();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dmem_req !== 1'b0 || lsu_busy !== 1'b0) begin failures++; $display("FAIL abort_async got req=%b busy=%b want 0 0", bus.dmem_req, lsu_busy); end
        checks++; if (bus.dmem_addr !== 32'h0 || bus.dmem_be !== 4'h0 || load_data !== 32'h0 || load_rd !== 5'd0)
            begin failures++; $display("FAIL abort_vals got a=%h be=%b ld=%h rd=%0d want 0", bus.dmem_addr, bus.dmem_be, load_data, load_rd); end
        step();
        rst_n = 1'b1;
        step();
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1111_2222;
        repeat (2) begin step(); bad |= load_valid | lsu_busy | bus.dmem_req | (load_data !== 32'h0); end
        bus.dmem_rvalid = 1'b0;
        step();
        bad |= load_valid | lsu_busy | bus.dmem_req;
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL abort_stray got bad=%b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_sb();
        test_fault();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
